// File: rtl/ewrapper_io_rx_align_pkg.sv
// Shared definitions for the frame-aligned receive deserializer.
//   WORD_BEATS   : link-clock cycles per 72-bit word (two bits per pin per cycle)
//   BYTE_W       : bits per pin per word
//   state_t      : aligner FSM encoding
//   is_lead_ones : classifies a frame byte as "ones then zeros" (FF, FE .. 80)
package ewrapper_io_rx_align_pkg;

    localparam int WORD_BEATS = 4;
    localparam int BYTE_W     = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // A byte is leading-ones-then-zeros when its complement is a contiguous run
    // of low-order ones (or zero); adding one to such a run clears every bit it
    // shares with itself. All-zero is excluded: that is a boundary, not a burst.
    function automatic logic is_lead_ones(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] inv;
        inv = ~b;
        return (b != '0) && ((inv & (inv + BYTE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ewrapper_io_rx_align_if.sv
// Bus between the IDDR even/odd pin registers and the aligned-word consumer.
//   clk_even/clk_odd : per-pin bits sampled first/second in the current cycle
//   rx_word          : aligned word, byte p = pin p, MSB of each byte earliest
//   rx_word_vld      : one-cycle strobe for rx_word
//   rx_locked        : aligner is locked to a frame
//   rx_offset        : lock phase (0 even-bit start, 1 odd-bit start)
//   align_err        : one-cycle pulse on a malformed frame byte
//   err_cnt          : saturating align_err count
// master drives the pin bits and observes the word; slave is the aligner.
interface ewrapper_io_rx_align_if #(
    parameter int PINS      = 9,
    parameter int ERR_CNT_W = 8
);
    logic [PINS-1:0]      clk_even;
    logic [PINS-1:0]      clk_odd;
    logic [8*PINS-1:0]    rx_word;
    logic                 rx_word_vld;
    logic                 rx_locked;
    logic                 rx_offset;
    logic                 align_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output clk_even, clk_odd,
        input  rx_word, rx_word_vld, rx_locked, rx_offset, align_err, err_cnt
    );

    modport slave (
        input  clk_even, clk_odd,
        output rx_word, rx_word_vld, rx_locked, rx_offset, align_err, err_cnt
    );
endinterface

// File: rtl/ewrapper_rx_pin_shift.sv
// Per-pin bit history and word-window select.
//   rxi_lclk, reset : link clock, async active-high reset
//   even, odd       : this pin's bits for the current cycle
//   offset          : locked word phase
//   beat            : aligner beat counter
//   window          : the 8 bits of the word ending this cycle (MSB earliest),
//                     zero on beats where no word ends
module ewrapper_rx_pin_shift
    import ewrapper_io_rx_align_pkg::*;
#(
    parameter int HIST_W = 10
) (
    input  logic              rxi_lclk,
    input  logic              reset,
    input  logic              even,
    input  logic              odd,
    input  logic              offset,
    input  logic [1:0]        beat,
    output logic [BYTE_W-1:0] window
);

    logic [HIST_W-1:0]             hist;
    logic [HIST_W+1:0]             cat;
    logic [$clog2(HIST_W+2)-1:0]   sel;
    logic                          capture;

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) hist <= '0;
        else       hist <= {hist[HIST_W-3:0], even, odd};
    end

    // Live bits join the history so the word completes in the same cycle its
    // last bit arrives. Offset-1 words end on the even bit, so the odd bit of
    // that cycle is skipped by starting the window one position up.
    assign cat     = {hist, even, odd};
    assign sel     = {{($bits(sel)-1){1'b0}}, offset};
    assign capture = (beat == (offset ? 2'd0 : 2'(WORD_BEATS-1)));
    assign window  = capture ? cat[sel +: BYTE_W] : '0;

endmodule

// File: rtl/ewrapper_io_rx_align.sv
// Frame-aligned deserializer in the fast link-clock domain. Hunts for the
// rising edge of the frame pin at half-cycle granularity, then emits one
// 72-bit word every 4 cycles while the frame byte stays all-ones.
//   rxi_lclk : link clock
//   reset    : async active-high reset
//   rx       : slave side of the pin/word bus
module ewrapper_io_rx_align
    import ewrapper_io_rx_align_pkg::*;
#(
    parameter int PINS      = 9,
    parameter int FRAME_PIN = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   rxi_lclk,
    input  logic                   reset,
    ewrapper_io_rx_align_if.slave  rx
);

    state_t                         state;
    logic [1:0]                     beat;
    logic                           prev_odd;
    logic [PINS-1:0][BYTE_W-1:0]    win;
    logic [PINS-1:0][BYTE_W-1:0]    word_q;
    logic                           vld_q;
    logic                           locked_q;
    logic                           offset_q;
    logic                           err_q;
    logic [ERR_CNT_W-1:0]           err_cnt_q;

    logic                           frame_even;
    logic                           frame_odd;
    logic                           rise_even;
    logic                           rise_odd;
    logic [1:0]                     end_beat;
    logic [BYTE_W-1:0]              fbyte;

    for (genvar g = 0; g < PINS; g++) begin : g_pin
        ewrapper_rx_pin_shift u_shift (
            .rxi_lclk (rxi_lclk),
            .reset    (reset),
            .even     (rx.clk_even[g]),
            .odd      (rx.clk_odd[g]),
            .offset   (offset_q),
            .beat     (beat),
            .window   (win[g])
        );
    end

    assign frame_even = rx.clk_even[FRAME_PIN];
    assign frame_odd  = rx.clk_odd[FRAME_PIN];
    // Rise into the even bit compares against last cycle's odd bit; rise into
    // the odd bit compares against this cycle's even bit.
    assign rise_even  = !prev_odd && frame_even;
    assign rise_odd   = !frame_even && frame_odd;
    assign end_beat   = offset_q ? 2'd0 : 2'(WORD_BEATS-1);
    assign fbyte      = win[FRAME_PIN];

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            beat      <= '0;
            prev_odd  <= 1'b0;
            word_q    <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            offset_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            prev_odd <= frame_odd;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                HUNT: begin
                    beat <= '0;
                    if (rise_even) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        offset_q <= 1'b0;
                        beat     <= 2'd1;
                    end else if (rise_odd) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        offset_q <= 1'b1;
                        beat     <= 2'd1;
                    end
                end
                LOCKED: begin
                    beat <= beat + 2'd1;
                    if (beat == end_beat) begin
                        if (is_lead_ones(fbyte)) begin
                            vld_q  <= 1'b1;
                            word_q <= win;
                        end else if (fbyte != '0) begin
                            err_q <= 1'b1;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                        end
                        if (fbyte != '1) begin
                            state    <= HUNT;
                            locked_q <= 1'b0;
                            // Offset-1 words end on the even bit; the odd bit of
                            // the same cycle may already start the next frame.
                            if (offset_q && rise_odd) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                                beat     <= 2'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign rx.rx_word     = word_q;
    assign rx.rx_word_vld = vld_q;
    assign rx.rx_locked   = locked_q;
    assign rx.rx_offset   = offset_q;
    assign rx.align_err   = err_q;
    assign rx.err_cnt     = err_cnt_q;

endmodule
